ahb2apb: RTL



---
 rtl/ahb2apb_if.sv | 57 +++++
 rtl/ahb2apb.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/ahb2apb_if.sv
`default_nettype none
// ============================================================================
// Module   : ahb2apb_if
// Purpose  : AHB-Lite slave side and APB3 master side signal bundle for the
//            ahb2apb bridge. The "slave" modport is the bridge's view; the
//            "master" modport is the surrounding system (AHB master, APB
//            peripheral). Optional APB4 strobes exist under AHB2APB_PSTRB_EN.
// Revision : 1.0 - initial release
// ============================================================================
interface ahb2apb_if #(
  parameter int P_ADDR_W = 16
);
  logic                ahb_hsel;
  logic [31:0]         ahb_haddr;
  logic [1:0]          ahb_htrans;
  logic                ahb_hwrite;
  logic [1:0]          ahb_hsize;
  logic [31:0]         ahb_hwdata;
  logic                ahb_hready;
  logic                ahb_hreadyout;
  logic                ahb_hresp;
  logic [31:0]         ahb_hrdata;
  logic [P_ADDR_W-1:0] apb_paddr;
  logic                apb_psel;
  logic                apb_penable;
  logic                apb_pwrite;
  logic [31:0]         apb_pwdata;
`ifdef AHB2APB_PSTRB_EN
  logic [3:0]          apb_pstrb;
`endif
  logic [31:0]         apb_prdata;
  logic                apb_pready;
  logic                apb_pslverr;

  modport slave (
    input  ahb_hsel, ahb_haddr, ahb_htrans, ahb_hwrite, ahb_hsize,
    input  ahb_hwdata, ahb_hready,
    output ahb_hreadyout, ahb_hresp, ahb_hrdata,
    output apb_paddr, apb_psel, apb_penable, apb_pwrite, apb_pwdata,
`ifdef AHB2APB_PSTRB_EN
    output apb_pstrb,
`endif
    input  apb_prdata, apb_pready, apb_pslverr
  );

  modport master (
    output ahb_hsel, ahb_haddr, ahb_htrans, ahb_hwrite, ahb_hsize,
    output ahb_hwdata, ahb_hready,
    input  ahb_hreadyout, ahb_hresp, ahb_hrdata,
    input  apb_paddr, apb_psel, apb_penable, apb_pwrite, apb_pwdata,
`ifdef AHB2APB_PSTRB_EN
    input  apb_pstrb,
`endif
    output apb_prdata, apb_pready, apb_pslverr
  );
endinterface
`default_nettype wire

// File: rtl/ahb2apb.sv
`default_nettype none
// ============================================================================
// Module   : ahb2apb
// Purpose  : AHB-Lite slave to APB3 master bridge. One APB transfer per
//            accepted AHB transfer, AHB wait states until APB completes,
//            PSLVERR or PREADY timeout reported as a two-cycle AHB ERROR.
//            All outputs are registered.
// Options  : AHB2APB_PSTRB_EN - adds APB4 write strobes (apb_pstrb).
// Revision : 1.0 - initial release
// ============================================================================
module ahb2apb #(
  parameter int P_ADDR_W  = 16,
  parameter int P_TIMEOUT = 256
) (
  input  logic       clk,
  input  logic       reset_n,
  ahb2apb_if.slave   bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WDATA  = 3'd1;
  localparam logic [2:0] S_SETUP  = 3'd2;
  localparam logic [2:0] S_ACCESS = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;
  localparam logic [2:0] S_ERR1   = 3'd5;
  localparam logic [2:0] S_ERR2   = 3'd6;

  localparam int CNT_W = $clog2(P_TIMEOUT) + 1;
  // Last ACCESS cycle index allowed before the transfer is abandoned.
  localparam logic [CNT_W-1:0] TO_LAST = (P_TIMEOUT == 0) ? '0 : CNT_W'(P_TIMEOUT - 1);

  logic [2:0]          r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [P_ADDR_W-1:0] r_paddr;
  logic                r_psel;
  logic                r_penable;
  logic                r_pwrite;
  logic [31:0]         r_pwdata;
  logic [1:0]          r_hsize;
  logic                r_hreadyout;
  logic                r_hresp;
  logic [31:0]         r_hrdata;

  logic w_can_accept;
  logic w_accept;
  logic w_timeout;
  logic w_unused;

  // A new address phase may only be taken where the previous data phase is
  // completing (or there is none), which allows back-to-back transfers.
  assign w_can_accept = (r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR2);
  assign w_accept     = w_can_accept & bus.ahb_hsel & bus.ahb_hready & bus.ahb_htrans[1];
  assign w_timeout    = (P_TIMEOUT != 0) && (r_cnt == TO_LAST);

  // Upper address bits, htrans[0] and the latched size carry no logic here.
  assign w_unused = ^{r_hsize, bus.ahb_htrans[0], bus.ahb_haddr};

  // Bridge state machine; every output is loaded with its value for the next state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_paddr     <= '0;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_pwdata    <= '0;
      r_hsize     <= '0;
      r_hreadyout <= 1'b1;
      r_hresp     <= 1'b0;
      r_hrdata    <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_ERR2: begin
          r_hresp <= 1'b0;
          if (w_accept) begin
            r_paddr     <= bus.ahb_haddr[P_ADDR_W-1:0];
            r_pwrite    <= bus.ahb_hwrite;
            r_hsize     <= bus.ahb_hsize;
            r_hreadyout <= 1'b0;
            if (bus.ahb_hwrite) begin
              // Write data only arrives in the following data phase.
              r_state <= S_WDATA;
            end else begin
              r_state <= S_SETUP;
              r_psel  <= 1'b1;
            end
          end else begin
            r_state     <= S_IDLE;
            r_hreadyout <= 1'b1;
          end
        end
        S_WDATA: begin
          r_pwdata <= bus.ahb_hwdata;
          r_psel   <= 1'b1;
          r_state  <= S_SETUP;
        end
        S_SETUP: begin
          r_penable <= 1'b1;
          r_state   <= S_ACCESS;
        end
        S_ACCESS: begin
          if (bus.apb_pready) begin
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_cnt     <= '0;
            if (!bus.apb_pslverr) begin
              if (!r_pwrite) begin
                r_hrdata <= bus.apb_prdata;
              end
              r_hreadyout <= 1'b1;
              r_state     <= S_DONE;
            end else begin
              r_hresp <= 1'b1;
              r_state <= S_ERR1;
            end
          end else if (w_timeout) begin
            // Peripheral never answered: abandon the APB transfer.
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_cnt     <= '0;
            r_hresp   <= 1'b1;
            r_state   <= S_ERR1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_ERR1: begin
          r_hreadyout <= 1'b1;
          r_state     <= S_ERR2;
        end
        default: begin
          r_state     <= S_IDLE;
          r_cnt       <= '0;
          r_psel      <= 1'b0;
          r_penable   <= 1'b0;
          r_hreadyout <= 1'b1;
          r_hresp     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.apb_paddr     = r_paddr;
  assign bus.apb_psel      = r_psel;
  assign bus.apb_penable   = r_penable;
  assign bus.apb_pwrite    = r_pwrite;
  assign bus.apb_pwdata    = r_pwdata;
  assign bus.ahb_hreadyout = r_hreadyout;
  assign bus.ahb_hresp     = r_hresp;
  assign bus.ahb_hrdata    = r_hrdata;

`ifdef AHB2APB_PSTRB_EN
  logic [3:0] r_pstrb;

  function automatic logic [3:0] lane_strb(input logic [1:0] sz, input logic [1:0] a);
    logic [3:0] s;
    case (sz)
      2'd0:    s = 4'b0001 << a;
      2'd1:    s = a[1] ? 4'b1100 : 4'b0011;
      default: s = 4'b1111;
    endcase
    return s;
  endfunction

  // Strobes are fixed at accept, so they stay stable through SETUP/ACCESS.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pstrb <= 4'b0000;
    end else if (w_accept) begin
      r_pstrb <= bus.ahb_hwrite ? lane_strb(bus.ahb_hsize, bus.ahb_haddr[1:0]) : 4'b0000;
    end
  end

  assign bus.apb_pstrb = r_pstrb;
`endif

endmodule
`default_nettype wire
